fc_result_streamer: RTL

- Output-side counterpart of the fully-connected layer's input controller. Its peer raises Dout_Valid when a layer's results are complete.
- The compute datapath writes NUM_OUT result words into a ping-pong buffer. Dout_Valid commits the filled bank.
- The block then transmits the committed bank as one AXI-Stream master frame, asserting TLAST on the final word.
- The compute side fills the other bank while the frame drains.

---
 rtl/fc_pkg.sv | 14 +
 rtl/fc_pingpong_buf.sv | 56 +++++
 rtl/fc_result_streamer.sv | 112 +++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer controllers: default sizes
// and the result-streamer FSM encoding.
package fc_pkg;

  localparam int FC_DATA_WIDTH = 32;
  localparam int FC_NUM_OUT    = 10;
  localparam int FC_ADDR_WIDTH = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } fc_state_t;

endpackage

// File: rtl/fc_pingpong_buf.sv
// Two-bank result buffer: the compute side writes one bank while the other
// bank is read out by the stream side. commit swaps the roles of the banks.
module fc_pingpong_buf
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int NUM_OUT    = FC_NUM_OUT,
  parameter int ADDR_WIDTH = FC_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  commit,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic                  wr_bank;
  logic                  rd_bank;
  logic [DATA_WIDTH-1:0] mem [2][NUM_OUT];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else if (commit) begin
      rd_bank <= wr_bank;
      wr_bank <= ~wr_bank;
    end
  end

  // Contents survive reset; addresses at or beyond NUM_OUT match no entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT; i++) begin
      if (wr_en && (wr_addr == ADDR_WIDTH'(i))) begin
        mem[wr_bank][i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (rd_idx == ADDR_WIDTH'(i)) begin
        rd_data = mem[rd_bank][i];
      end
    end
  end

  // Word 0 of the bank about to be committed, forwarding a same-cycle write.
  assign head_data = (wr_en && (wr_addr == '0)) ? wr_data : mem[wr_bank][0];

endmodule

// File: rtl/fc_result_streamer.sv
// Sends a committed ping-pong bank as one AXI-Stream frame of NUM_OUT words.
// Handshake: a beat transfers on a rising edge with TVALID & TREADY; once raised,
// TVALID, TDATA and TLAST hold until that handshake.
module fc_result_streamer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int NUM_OUT    = FC_NUM_OUT,
  parameter int ADDR_WIDTH = FC_ADDR_WIDTH
) (
  input  logic                  M_AXIS_ACLK,
  input  logic                  M_AXIS_ARESET,
  input  logic                  Wr_En,
  input  logic [ADDR_WIDTH-1:0] Wr_Addr,
  input  logic [DATA_WIDTH-1:0] Wr_Data,
  input  logic                  Dout_Valid,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  Busy,
  output logic                  Overrun
);

  fc_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  overrun_q, overrun_d;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] head_data;

  fc_pingpong_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_OUT   (NUM_OUT),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_buf (
    .clk      (M_AXIS_ACLK),
    .rst      (M_AXIS_ARESET),
    .wr_en    (Wr_En),
    .wr_addr  (Wr_Addr),
    .wr_data  (Wr_Data),
    .commit   (commit),
    .rd_idx   (ptr_q),
    .rd_data  (rd_data),
    .head_data(head_data)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    overrun_d = overrun_q;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Dout_Valid) begin
          commit   = 1'b1;
          tdata_d  = head_data;
          tvalid_d = 1'b1;
          tlast_d  = (NUM_OUT == 1);
          ptr_d    = ADDR_WIDTH'(1);
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        // A commit request during a frame, even on its final beat, is lost.
        if (Dout_Valid) overrun_d = 1'b1;
        if (tvalid_q && M_AXIS_TREADY) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            tdata_d = rd_data;
            tlast_d = (ptr_q == ADDR_WIDTH'(NUM_OUT - 1));
            ptr_d   = ptr_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      overrun_q <= overrun_d;
    end
  end

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign Busy          = (state_q == ST_SEND);
  assign Overrun       = overrun_q;

endmodule
